// File: rtl/seq_div32_if.sv
// rtl/seq_div32_if.sv - request/result bundle between EX operand select and the sequential divider
interface seq_div32_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   // issuing side (pipeline / bench)
   modport master (
      output start, is_signed, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   // divider side
   modport slave (
      input  start, is_signed, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_div32.sv
// rtl/seq_div32.sv - multi-cycle restoring 32-bit divider for DIV/DIVU feeding HI/LO
module seq_div32 #(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic        clk,
   input  logic        rst,
   seq_div32_if.slave  bus
);
   localparam int CW = $clog2(ITER);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t           state, state_nx;
   logic             accept;
   logic             by_zero;
   logic [WIDTH-1:0] dvd_abs, dsr_abs;
   logic [WIDTH:0]   trial;

   // working registers: partial remainder, dividend/quotient shifter, divisor magnitude
   logic [WIDTH-1:0] rem_r, q_r, dsr_r;
   logic             neg_q, neg_r;
   logic [CW-1:0]    cnt;

   // output registers
   logic             busy_r, done_r, dbz_r;
   logic [WIDTH-1:0] quo_r, rmd_r;

   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.quotient    = quo_r;
   assign bus.remainder   = rmd_r;
   assign bus.div_by_zero = dbz_r;

   // operand magnitudes (only for DIV) and the 33-bit trial subtraction
   always_comb begin
      by_zero = (bus.divisor == '0);
      dvd_abs = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
      dsr_abs = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
      trial   = {rem_r, q_r[WIDTH-1]} - {1'b0, dsr_r};
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next state; a start is only taken in IDLE or in the DONE cycle
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               accept   = 1'b1;
               state_nx = by_zero ? DONE : RUN;
            end else begin
               state_nx = IDLE;
            end
         end
         RUN:     if (cnt == CW'(ITER - 1)) state_nx = FIX;
         FIX:     state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   // busy/done registered from the upcoming state so they line up with it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state_nx == RUN) || (state_nx == FIX);
         done_r <= (state_nx == DONE);
      end
   end

   // datapath: load on accept, one quotient bit per RUN cycle, sign fixup in FIX
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_r <= '0;
         q_r   <= '0;
         dsr_r <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         cnt   <= '0;
         quo_r <= '0;
         rmd_r <= '0;
         dbz_r <= 1'b0;
      end else if (accept) begin
         neg_r <= bus.is_signed & bus.dividend[WIDTH-1];
         neg_q <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
         q_r   <= dvd_abs;
         dsr_r <= dsr_abs;
         rem_r <= '0;
         cnt   <= '0;
         if (by_zero) begin
            quo_r <= '1;
            rmd_r <= bus.dividend;
            dbz_r <= 1'b1;
         end
      end else if (state == RUN) begin
         rem_r <= trial[WIDTH] ? {rem_r[WIDTH-2:0], q_r[WIDTH-1]} : trial[WIDTH-1:0];
         q_r   <= {q_r[WIDTH-2:0], ~trial[WIDTH]};
         cnt   <= cnt + 1'b1;
      end else if (state == FIX) begin
         quo_r <= neg_q ? -q_r : q_r;
         rmd_r <= neg_r ? -rem_r : rem_r;
         dbz_r <= 1'b0;
      end
   end
endmodule

// File: tb/tb_seq_div32.sv
// tb/tb_seq_div32.sv - directed self-checking bench for seq_div32 with an arithmetic reference model
module tb_seq_div32;
   logic clk = 1'b0;
   logic rst = 1'b1;

   seq_div32_if #(.WIDTH(32)) bus ();

   seq_div32 #(.WIDTH(32), .ITER(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // reference: plain arithmetic on the operands
   function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r, output logic z);
      z = 1'b0;
      if (b == 32'h0) begin
         q = 32'hFFFFFFFF;
         r = a;
         z = 1'b1;
      end else if (!s) begin
         q = a / b;
         r = a % b;
      end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
         q = 32'h80000000;
         r = 32'h0;
      end else begin
         q = 32'($signed(a) / $signed(b));
         r = 32'($signed(a) % $signed(b));
      end
   endfunction

   // model state, indexed by rising-edge count
   int          cyc     = 0;
   int          done_e  = -100;
   int          busy_lo = -100;
   int          busy_hi = -200;
   int          upd_e   = -100;
   logic [31:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
   logic        m_z = 1'b0, p_z = 1'b0;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         done_e = -100; busy_lo = -100; busy_hi = -200; upd_e = -100;
         m_q = '0; m_r = '0; m_z = 1'b0;
      end else begin
         cyc = cyc + 1;
         if (cyc == upd_e) begin
            m_q = p_q; m_r = p_r; m_z = p_z;
         end
         if (bus.start && cyc > done_e) begin
            model(bus.is_signed, bus.dividend, bus.divisor, p_q, p_r, p_z);
            busy_lo = cyc;
            if (p_z) begin
               done_e = cyc; busy_hi = cyc - 1; upd_e = cyc;
               m_q = p_q; m_r = p_r; m_z = p_z;
            end else begin
               done_e = cyc + 33; busy_hi = cyc + 32; upd_e = cyc + 33;
            end
         end
      end
   end

   // every-cycle comparison against the model
   initial forever begin
      int e;
      @(negedge clk);
      e = cyc;
      if (rst) begin
         chk("busy_m", bus.busy, 0);
         chk("done_m", bus.done, 0);
         chk("quot_m", bus.quotient, 0);
         chk("rem_m", bus.remainder, 0);
         chk("dbz_m", bus.div_by_zero, 0);
      end else begin
         chk("busy_m", bus.busy, (e >= busy_lo && e <= busy_hi) ? 1 : 0);
         chk("done_m", bus.done, (e == done_e) ? 1 : 0);
         chk("quot_m", bus.quotient, m_q);
         chk("rem_m", bus.remainder, m_r);
         chk("dbz_m", bus.div_by_zero, m_z);
      end
   end

   // issue one operation and check literal expectations at done
   task automatic op(input logic s, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er, input logic ez,
                     input bit b2b, input bit poke);
      int n;
      int nb;
      bit seen;
      if (!b2b) begin
         @(posedge clk); #1;
      end
      bus.start = 1'b1; bus.is_signed = s; bus.dividend = a; bus.divisor = b;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.is_signed = ~s; bus.dividend = ~a; bus.divisor = b ^ 32'h1234;
      n = 0; nb = 0; seen = 1'b0;
      while (!seen && n < 60) begin
         @(negedge clk);
         n++;
         if (bus.busy) nb++;
         if (bus.done) seen = 1'b1;
         if (poke && n == 5) begin
            bus.start = 1'b1; bus.dividend = 32'h0000DEAD; bus.divisor = 32'h3;
         end
         if (poke && n == 7) bus.start = 1'b0;
      end
      chk("latency", 32'(n), ez ? 32'd1 : 32'd34);
      chk("busy_cycles", 32'(nb), ez ? 32'd0 : 32'd33);
      chk("quotient", bus.quotient, eq);
      chk("remainder", bus.remainder, er);
      chk("div_by_zero", bus.div_by_zero, ez);
   endtask

   initial begin
      bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
      #12;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_quot", bus.quotient, 0);
      chk("rst_rem", bus.remainder, 0);
      #10 rst = 1'b0;

      op(0, 32'd100,        32'd7,        32'd14,       32'd2,        0, 0, 0);
      op(1, 32'hFFFFFFF9,   32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0, 0);
      op(1, 32'h00000007,   32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 0, 0, 0);
      op(0, 32'hFFFFFFFF,   32'h80000001, 32'h00000001, 32'h7FFFFFFE, 0, 0, 0);
      op(1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'h00000000, 0, 0, 0);
      op(0, 32'd5,          32'd0,        32'hFFFFFFFF, 32'd5,        1, 0, 0);
      op(0, 32'd100,        32'd7,        32'd14,       32'd2,        0, 0, 0);
      op(0, 32'd1000,       32'd10,       32'd100,      32'd0,        0, 0, 1);
      op(0, 32'hFFFFFFFF,   32'd3,        32'h55555555, 32'd0,        0, 0, 0);
      op(1, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 0, 1, 0);
      op(1, 32'hFFFFFFFB,   32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1, 0, 0);
      op(0, 32'd77,         32'd5,        32'd15,       32'd2,        0, 0, 0);

      // asynchronous reset in the middle of RUN
      @(posedge clk); #1;
      bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      chk("pre_rst_busy", bus.busy, 1);
      rst = 1'b1;
      #1;
      chk("arst_busy", bus.busy, 0);
      chk("arst_done", bus.done, 0);
      chk("arst_quot", bus.quotient, 0);
      chk("arst_rem", bus.remainder, 0);
      chk("arst_dbz", bus.div_by_zero, 0);
      @(negedge clk); #2;
      rst = 1'b0;
      op(0, 32'd100,        32'd7,        32'd14,       32'd2,        0, 0, 0);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
